// File: rtl/user_au_obi_reader.sv
// user_au_obi_reader: OBI manager that fetches a block of 32-bit samples
// from memory and streams them out through a small sample FIFO.

package user_au_obi_pkg;
   localparam int unsigned AddrWidth = 32;
   localparam int unsigned IdWidth   = 1;

   typedef struct packed {
      logic [AddrWidth-1:0] addr;
      logic                 we;
      logic [3:0]           be;
      logic [31:0]          wdata;
      logic [IdWidth-1:0]   aid;
   } obi_a_t;

   typedef struct packed {
      logic   req;
      obi_a_t a;
   } obi_req_t;

   typedef struct packed {
      logic [31:0] rdata;
      logic        err;
   } obi_r_t;

   typedef struct packed {
      logic   gnt;
      logic   rvalid;
      obi_r_t r;
   } obi_rsp_t;
endpackage

module user_au_obi_reader
   import user_au_obi_pkg::*;
#(
   parameter int unsigned FifoDepth = 4
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   output obi_req_t             obi_req_o,
   input  obi_rsp_t             obi_rsp_i,
   input  logic                 start_i,
   input  logic                 stop_i,
   input  logic [AddrWidth-1:0] base_addr_i,
   input  logic [15:0]          len_i,
   input  logic                 loop_i,
   output logic                 busy_o,
   output logic                 done_o,
   output logic                 err_o,
   output logic [31:0]          data_o,
   output logic                 valid_o,
   input  logic                 ready_i
);

   localparam int unsigned PtrW = $clog2(FifoDepth);
   localparam int unsigned CntW = $clog2(FifoDepth + 1);

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      WAIT,
      FLUSH
   } state_e;

   state_e               state_q, state_d;
   logic [15:0]          idx_q, idx_d;
   logic [15:0]          len_q, len_d;
   logic [AddrWidth-1:0] base_q, base_d;
   logic                 loop_q, loop_d;
   logic                 err_q, err_d;
   logic                 done_q, done_d;
   logic                 pend_q, pend_d;
   logic [PtrW-1:0]      wptr_q, wptr_d;
   logic [PtrW-1:0]      rptr_q, rptr_d;
   logic [CntW-1:0]      cnt_q, cnt_d;
   logic [31:0]          mem_q [FifoDepth];

   logic            push, pop, clr, free, last;
   logic [CntW-1:0] cnt_after;

   // Next-state logic: transfer sequencing, FIFO bookkeeping, OBI request.
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      len_d     = len_q;
      base_d    = base_q;
      loop_d    = loop_q;
      err_d     = err_q;
      done_d    = 1'b0;
      pend_d    = pend_q;
      clr       = 1'b0;
      obi_req_o = '0;

      push = (state_q == WAIT) && pend_q && obi_rsp_i.rvalid
             && !obi_rsp_i.r.err && !stop_i;
      pop  = (cnt_q != '0) && ready_i;
      cnt_after = cnt_q + CntW'(push) - CntW'(pop);
      free = cnt_after < CntW'(FifoDepth);
      last = idx_q == (len_q - 16'd1);

      unique case (state_q)
         IDLE: begin
            if (start_i) begin
               base_d = base_addr_i & ~AddrWidth'(3);
               len_d  = len_i;
               loop_d = loop_i;
               err_d  = 1'b0;
               idx_d  = '0;
               pend_d = 1'b0;
               if (len_i == '0) begin
                  done_d = 1'b1;
               end else begin
                  state_d = free ? REQ : WAIT;
               end
            end
         end
         REQ: begin
            obi_req_o.req    = 1'b1;
            obi_req_o.a.be   = 4'hF;
            obi_req_o.a.addr = base_q + AddrWidth'({idx_q, 2'b00});
            if (stop_i) begin
               clr     = 1'b1;
               pend_d  = obi_rsp_i.gnt;
               state_d = obi_rsp_i.gnt ? FLUSH : IDLE;
            end else if (obi_rsp_i.gnt) begin
               pend_d  = 1'b1;
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (stop_i) begin
               clr     = 1'b1;
               pend_d  = pend_q && !obi_rsp_i.rvalid;
               state_d = pend_d ? FLUSH : IDLE;
            end else if (pend_q && obi_rsp_i.rvalid) begin
               pend_d = 1'b0;
               if (obi_rsp_i.r.err) begin
                  err_d   = 1'b1;
                  state_d = IDLE;
               end else if (last && !loop_q) begin
                  done_d  = 1'b1;
                  state_d = IDLE;
               end else begin
                  idx_d   = last ? '0 : idx_q + 16'd1;
                  state_d = free ? REQ : WAIT;
               end
            end else if (!pend_q && free) begin
               state_d = REQ;
            end
         end
         FLUSH: begin
            if (obi_rsp_i.rvalid) begin
               pend_d  = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      if (clr) begin
         wptr_d = '0;
         rptr_d = '0;
         cnt_d  = '0;
      end else begin
         wptr_d = wptr_q + PtrW'(push);
         rptr_d = rptr_q + PtrW'(pop);
         cnt_d  = cnt_after;
      end
   end

   // Control and FIFO pointer registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         idx_q   <= '0;
         len_q   <= '0;
         base_q  <= '0;
         loop_q  <= 1'b0;
         err_q   <= 1'b0;
         done_q  <= 1'b0;
         pend_q  <= 1'b0;
         wptr_q  <= '0;
         rptr_q  <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         len_q   <= len_d;
         base_q  <= base_d;
         loop_q  <= loop_d;
         err_q   <= err_d;
         done_q  <= done_d;
         pend_q  <= pend_d;
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         cnt_q   <= cnt_d;
      end
   end

   // Sample storage; validity is tracked by the count, so no reset needed.
   always_ff @(posedge clk_i) begin
      if (push) begin
         mem_q[wptr_q] <= obi_rsp_i.r.rdata;
      end
   end

   assign busy_o  = state_q != IDLE;
   assign done_o  = done_q;
   assign err_o   = err_q;
   assign valid_o = cnt_q != '0;
   assign data_o  = valid_o ? mem_q[rptr_q] : '0;

endmodule
